// File: rtl/and_arbiter.sv
// Round-robin arbiter over N requesters; the winner's a & b is registered into a
// single output slot with a valid/ready handshake and the owner's index.
module and_arbiter #(
   parameter int N  = 4,
   parameter int W  = 8,
   parameter int IW = (N > 2) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [N-1:0]    req,
   input  logic [N*W-1:0]  a,
   input  logic [N*W-1:0]  b,
   output logic [N-1:0]    gnt,
   output logic [W-1:0]    y,
   output logic            y_valid,
   input  logic            y_ready,
   output logic [IW-1:0]   y_id
);

   localparam logic [IW-1:0] LAST = IW'(N - 1);

   logic [IW-1:0]         r_ptr;
   logic [W-1:0]          r_y;
   logic                  r_y_valid;
   logic [IW-1:0]         r_y_id;

   logic [N-1:0][W-1:0]   w_and;
   logic                  w_free;
   logic                  w_hit;
   logic                  w_grant;
   logic [IW-1:0]         w_idx;
   logic [IW:0]           w_sum;
   logic [IW-1:0]         w_j;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_lane
         assign w_and[gi] = a[gi*W +: W] & b[gi*W +: W];
      end
   endgenerate

   // Circular search from r_ptr; the extra sum bit lets non-power-of-two N wrap cleanly.
   always_comb begin
      w_hit = 1'b0;
      w_idx = '0;
      w_sum = '0;
      w_j   = '0;
      for (int k = 0; k < N; k++) begin
         w_sum = {1'b0, r_ptr} + (IW+1)'(k);
         if (w_sum >= (IW+1)'(N))
            w_sum = w_sum - (IW+1)'(N);
         w_j = w_sum[IW-1:0];
         if (!w_hit && req[w_j]) begin
            w_hit = 1'b1;
            w_idx = w_j;
         end
      end
   end

   assign w_free  = !r_y_valid || y_ready;
   assign w_grant = !rst && en && w_hit && w_free;
   assign gnt     = w_grant ? (N'(1) << w_idx) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr     <= '0;
         r_y       <= '0;
         r_y_valid <= 1'b0;
         r_y_id    <= '0;
      end else if (w_grant) begin
         r_y       <= w_and[w_idx];
         r_y_id    <= w_idx;
         r_y_valid <= 1'b1;
         r_ptr     <= (w_idx == LAST) ? '0 : w_idx + 1'b1;
      end else if (y_ready) begin
         r_y_valid <= 1'b0;
      end
   end

   assign y       = r_y;
   assign y_valid = r_y_valid;
   assign y_id    = r_y_id;

endmodule

// File: tb/tb_and_arbiter.sv
// Scenario bench for and_arbiter (N=4, W=8): directed spec scenarios plus a
// randomized pass against a small reference model, results through a scoreboard.
module tb_and_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int IW = 2;

   typedef struct packed {
      logic [IW-1:0] id;
      logic [W-1:0]  y;
   } exp_t;

   logic            clk;
   logic            rst;
   logic            en;
   logic [N-1:0]    req;
   logic [N*W-1:0]  a;
   logic [N*W-1:0]  b;
   logic [N-1:0]    gnt;
   logic [W-1:0]    y;
   logic            y_valid;
   logic            y_ready;
   logic [IW-1:0]   y_id;

   logic [W-1:0]    av [N];
   logic [W-1:0]    bv [N];
   exp_t            sb [$];
   int              errors = 0;
   int              checks = 0;

   always_comb begin
      a = {av[3], av[2], av[1], av[0]};
      b = {bv[3], bv[2], bv[1], bv[0]};
   end

   and_arbiter #(.N(N), .W(W), .IW(IW)) dut (
      .clk(clk), .rst(rst), .en(en), .req(req), .a(a), .b(b),
      .gnt(gnt), .y(y), .y_valid(y_valid), .y_ready(y_ready), .y_id(y_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      req = '0; en = 1'b1; y_ready = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      exp_t e;
      rst = 1'b1; en = 1'b1; req = 4'b1111; y_ready = 1'b1;
      #1;
      checks++;
      if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
      tick();
      checks++;
      if (y !== 8'h00 || y_valid !== 1'b0 || y_id !== 2'd0) begin
         errors++; $display("FAIL rst_state got y=%h v=%b id=%0d exp y=00 v=0 id=0", y, y_valid, y_id);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (gnt !== 4'b0001) begin errors++; $display("FAIL first_gnt got=%b exp=0001", gnt); end
      sb.push_back('{id: 2'd0, y: av[0] & bv[0]});
      tick();
      e = sb.pop_front();
      checks++;
      if (y !== e.y || y_id !== e.id || y_valid !== 1'b1) begin
         errors++; $display("FAIL first_result got y=%h id=%0d v=%b exp y=%h id=%0d v=1", y, y_id, y_valid, e.y, e.id);
      end
      drain();
   endtask

   task automatic test_single();
      exp_t e;
      av[2] = 8'hF0; bv[2] = 8'h3C;
      req = 4'b0100;
      #1;
      checks++;
      if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
      sb.push_back('{id: 2'd2, y: 8'h30});
      tick();
      e = sb.pop_front();
      checks++;
      if (y !== e.y || y_id !== e.id || y_valid !== 1'b1) begin
         errors++; $display("FAIL single_result got y=%h id=%0d v=%b exp y=%h id=%0d v=1", y, y_id, y_valid, e.y, e.id);
      end
      req = 4'b1111;
      #1;
      checks++;
      if (gnt !== 4'b1000) begin errors++; $display("FAIL single_next_ptr got=%b exp=1000", gnt); end
      sb.push_back('{id: 2'd3, y: av[3] & bv[3]});
      tick();
      e = sb.pop_front();
      checks++;
      if (y !== e.y || y_id !== e.id) begin
         errors++; $display("FAIL single_next_result got y=%h id=%0d exp y=%h id=%0d", y, y_id, e.y, e.id);
      end
      drain();
   endtask

   task automatic test_fairness();
      exp_t e;
      logic [N-1:0] eg;
      req = 4'b1111; y_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         eg = 4'b0001 << (k % N);
         #1;
         checks++;
         if (gnt !== eg) begin errors++; $display("FAIL fair_gnt[%0d] got=%b exp=%b", k, gnt, eg); end
         sb.push_back('{id: IW'(k % N), y: av[k % N] & bv[k % N]});
         tick();
         e = sb.pop_front();
         checks++;
         if (y !== e.y || y_id !== e.id || y_valid !== 1'b1) begin
            errors++; $display("FAIL fair_result[%0d] got y=%h id=%0d v=%b exp y=%h id=%0d v=1", k, y, y_id, y_valid, e.y, e.id);
         end
      end
      drain();
   endtask

   task automatic test_backpressure();
      exp_t e;
      av[2] = 8'h0F; bv[2] = 8'hFF;
      req = 4'b1111; y_ready = 1'b0;
      #1;
      checks++;
      if (gnt !== 4'b0100) begin errors++; $display("FAIL bp_first_gnt got=%b exp=0100", gnt); end
      sb.push_back('{id: 2'd2, y: 8'h0F});
      tick();
      e = sb.pop_front();
      checks++;
      if (y !== e.y || y_id !== e.id || y_valid !== 1'b1) begin
         errors++; $display("FAIL bp_first_result got y=%h id=%0d v=%b exp y=%h id=%0d v=1", y, y_id, y_valid, e.y, e.id);
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (gnt !== 4'b0000) begin errors++; $display("FAIL bp_hold_gnt[%0d] got=%b exp=0000", k, gnt); end
         tick();
         checks++;
         if (y !== 8'h0F || y_id !== 2'd2 || y_valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold[%0d] got y=%h id=%0d v=%b exp y=0f id=2 v=1", k, y, y_id, y_valid);
         end
      end
      y_ready = 1'b1;
      #1;
      checks++;
      if (gnt !== 4'b1000) begin errors++; $display("FAIL bp_release_gnt got=%b exp=1000", gnt); end
      sb.push_back('{id: 2'd3, y: av[3] & bv[3]});
      tick();
      e = sb.pop_front();
      checks++;
      if (y !== e.y || y_id !== e.id || y_valid !== 1'b1) begin
         errors++; $display("FAIL bp_release_result got y=%h id=%0d v=%b exp y=%h id=%0d v=1", y, y_id, y_valid, e.y, e.id);
      end
      drain();
   endtask

   task automatic test_enable();
      exp_t e;
      req = 4'b1111; en = 1'b1; y_ready = 1'b0;
      #1;
      checks++;
      if (gnt !== 4'b0001) begin errors++; $display("FAIL en_first_gnt got=%b exp=0001", gnt); end
      sb.push_back('{id: 2'd0, y: av[0] & bv[0]});
      tick();
      e = sb.pop_front();
      checks++;
      if (y !== e.y || y_id !== e.id || y_valid !== 1'b1) begin
         errors++; $display("FAIL en_first_result got y=%h id=%0d v=%b exp y=%h id=%0d v=1", y, y_id, y_valid, e.y, e.id);
      end
      en = 1'b0;
      #1;
      checks++;
      if (gnt !== 4'b0000) begin errors++; $display("FAIL en_off_gnt0 got=%b exp=0000", gnt); end
      tick();
      checks++;
      if (y_valid !== 1'b1 || y_id !== 2'd0) begin
         errors++; $display("FAIL en_off_hold got v=%b id=%0d exp v=1 id=0", y_valid, y_id);
      end
      y_ready = 1'b1;
      #1;
      checks++;
      if (gnt !== 4'b0000) begin errors++; $display("FAIL en_off_gnt1 got=%b exp=0000", gnt); end
      tick();
      checks++;
      if (y_valid !== 1'b0) begin errors++; $display("FAIL en_off_delivered got v=%b exp v=0", y_valid); end
      #1;
      checks++;
      if (gnt !== 4'b0000) begin errors++; $display("FAIL en_off_gnt2 got=%b exp=0000", gnt); end
      tick();
      en = 1'b1;
      #1;
      checks++;
      if (gnt !== 4'b0010) begin errors++; $display("FAIL en_back_gnt got=%b exp=0010", gnt); end
      sb.push_back('{id: 2'd1, y: av[1] & bv[1]});
      tick();
      e = sb.pop_front();
      checks++;
      if (y !== e.y || y_id !== e.id) begin
         errors++; $display("FAIL en_back_result got y=%h id=%0d exp y=%h id=%0d", y, y_id, e.y, e.id);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      exp_t e;
      av[1] = 8'hAA; bv[1] = 8'hFF;
      req = 4'b0010; y_ready = 1'b0;
      #1;
      checks++;
      if (gnt !== 4'b0010) begin errors++; $display("FAIL rmid_setup_gnt got=%b exp=0010", gnt); end
      sb.push_back('{id: 2'd1, y: 8'hAA});
      tick();
      e = sb.pop_front();
      checks++;
      if (y !== e.y || y_valid !== 1'b1) begin
         errors++; $display("FAIL rmid_setup_result got y=%h v=%b exp y=%h v=1", y, y_valid, e.y);
      end
      rst = 1'b1; req = 4'b1111;
      #1;
      checks++;
      if (gnt !== 4'b0000) begin errors++; $display("FAIL rmid_gnt got=%b exp=0000", gnt); end
      tick();
      sb.delete();
      checks++;
      if (y !== 8'h00 || y_valid !== 1'b0 || y_id !== 2'd0) begin
         errors++; $display("FAIL rmid_state got y=%h v=%b id=%0d exp y=00 v=0 id=0", y, y_valid, y_id);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (gnt !== 4'b0001) begin errors++; $display("FAIL rmid_after_gnt got=%b exp=0001", gnt); end
      sb.push_back('{id: 2'd0, y: av[0] & bv[0]});
      tick();
      e = sb.pop_front();
      checks++;
      if (y !== e.y || y_id !== e.id || y_valid !== 1'b1) begin
         errors++; $display("FAIL rmid_after_result got y=%h id=%0d v=%b exp y=%h id=%0d v=1", y, y_id, y_valid, e.y, e.id);
      end
      drain();
   endtask

   function automatic int model_pick(logic [N-1:0] r, int p);
      for (int k = 0; k < N; k++)
         if (r[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic test_random();
      exp_t e;
      int m_ptr, pick;
      logic m_valid;
      logic [W-1:0] m_y;
      logic [IW-1:0] m_id;
      logic [N-1:0] eg;
      rst = 1'b1; req = '0; y_ready = 1'b1;
      tick();
      rst = 1'b0;
      m_ptr = 0; m_valid = 1'b0; m_y = '0; m_id = '0;
      for (int c = 0; c < 300; c++) begin
         req = N'($urandom_range(0, 15));
         en = ($urandom_range(0, 3) != 0);
         y_ready = ($urandom_range(0, 2) != 0);
         for (int i = 0; i < N; i++) begin av[i] = W'($urandom); bv[i] = W'($urandom); end
         #1;
         pick = model_pick(req, m_ptr);
         eg = (en && (!m_valid || y_ready) && pick >= 0) ? N'(1) << pick : '0;
         checks++;
         if (gnt !== eg) begin errors++; $display("FAIL rand_gnt[%0d] got=%b exp=%b", c, gnt, eg); end
         if (eg != '0) sb.push_back('{id: IW'(pick), y: av[pick] & bv[pick]});
         tick();
         if (eg != '0) begin
            e = sb.pop_front();
            m_y = e.y; m_id = e.id; m_valid = 1'b1; m_ptr = (pick + 1) % N;
         end else if (y_ready) begin
            m_valid = 1'b0;
         end
         checks++;
         if (y !== m_y || y_id !== m_id || y_valid !== m_valid) begin
            errors++; $display("FAIL rand_out[%0d] got y=%h id=%0d v=%b exp y=%h id=%0d v=%b", c, y, y_id, y_valid, m_y, m_id, m_valid);
         end
      end
      drain();
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         av[i] = 8'h5A ^ W'(8'h11 * (i + 1));
         bv[i] = 8'hF3 - W'(8'h21 * i);
      end
      rst = 1'b1; en = 1'b0; req = '0; y_ready = 1'b0;
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_enable();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
